// File: rtl/viterbi_frame_controller_if.sv
// Purpose: bundles the upstream, decoder, downstream and status signals of the Viterbi frame controller.
// Latency: none, wiring only.
// Backpressure: carries InReady (controller to upstream) and OutReady (downstream to controller).
//
// Signals:
//   upstream   : InData, InValid, InLast, InReady
//   decoder    : DecStart, DecInput, DecOutput, DecOutValid
//   downstream : OutData, OutValid, OutReady, OutLast
//   status     : FrameError, Timeout, Busy, FrameCount[7:0]
// Modports: master = surrounding environment (upstream source, decoder, downstream sink),
//           slave  = the frame controller itself.
interface viterbi_frame_controller_if;
   logic       InData;
   logic       InValid;
   logic       InLast;
   logic       InReady;
   logic       DecStart;
   logic       DecInput;
   logic       DecOutput;
   logic       DecOutValid;
   logic       OutData;
   logic       OutValid;
   logic       OutReady;
   logic       OutLast;
   logic       FrameError;
   logic       Timeout;
   logic       Busy;
   logic [7:0] FrameCount;

   modport master (
      output InData, InValid, InLast, DecOutput, DecOutValid, OutReady,
      input  InReady, DecStart, DecInput, OutData, OutValid, OutLast,
      input  FrameError, Timeout, Busy, FrameCount
   );

   modport slave (
      input  InData, InValid, InLast, DecOutput, DecOutValid, OutReady,
      output InReady, DecStart, DecInput, OutData, OutValid, OutLast,
      output FrameError, Timeout, Busy, FrameCount
   );
endinterface

// File: rtl/viterbi_frame_controller.sv
// Purpose: buffers one coded frame, replays it into a Viterbi decoder, captures the decoded bits and drains them downstream.
// Latency: CODED_LENGTH load cycles + CODED_LENGTH feed cycles + decoder time (bounded by TIMEOUT) + MAX_LENGTH drain handshakes.
// Backpressure: InReady only while loading; the decoder feed has none; drain advances only on OutValid & OutReady.
//
// Ports:
//   Clock, Reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : upstream InData/InValid/InLast/InReady, decoder DecStart/DecInput/DecOutput/DecOutValid,
//                  downstream OutData/OutValid/OutReady/OutLast, status FrameError/Timeout/Busy/FrameCount
module viterbi_frame_controller #(
   parameter int MAX_LENGTH   = 192,
   parameter int CODED_LENGTH = 2 * MAX_LENGTH,
   parameter int TIMEOUT      = 1024
) (
   input  logic                        Clock,
   input  logic                        Reset,
   viterbi_frame_controller_if.slave   bus
);

   localparam logic [8:0]  CODED_LAST = 9'(CODED_LENGTH - 1);
   localparam logic [7:0]  DEC_LAST   = 8'(MAX_LENGTH - 1);
   localparam logic [10:0] TMO_LAST   = 11'(TIMEOUT - 1);

   typedef enum logic [1:0] {LOAD, FEED, CAPTURE, DRAIN} state_t;

   state_t state_q, state_d;

   logic [8:0]  wr_cnt;
   logic [8:0]  rd_cnt;
   logic [7:0]  cap_cnt;
   logic [10:0] tmo_cnt;
   logic [7:0]  out_cnt;
   logic [7:0]  frame_count;
   logic        frame_err_q;

   // Frame storage carries no reset: contents are rewritten before every use.
   logic [CODED_LENGTH-1:0] coded_buf;
   logic [MAX_LENGTH-1:0]   dec_buf;

   logic cap_done;

   // Last decoded bit of the frame arrives this cycle; it outranks a simultaneous timeout.
   assign cap_done = (state_q == CAPTURE) && bus.DecOutValid && (cap_cnt == DEC_LAST);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.InReady  = 1'b0;
      bus.OutValid = 1'b0;
      bus.DecStart = 1'b0;
      bus.DecInput = 1'b0;
      bus.OutData  = 1'b0;
      bus.OutLast  = 1'b0;
      bus.Timeout  = 1'b0;
      unique case (state_q)
         LOAD: begin
            bus.InReady = 1'b1;
            // Reaching the last slot ends the frame even without InLast.
            if (bus.InValid && (wr_cnt == CODED_LAST)) begin
               state_d = FEED;
            end
         end
         FEED: begin
            bus.DecStart = (rd_cnt == 9'd0);
            bus.DecInput = coded_buf[rd_cnt];
            if (rd_cnt == CODED_LAST) begin
               state_d = CAPTURE;
            end
         end
         CAPTURE: begin
            if (cap_done) begin
               state_d = DRAIN;
            end else if (tmo_cnt == TMO_LAST) begin
               bus.Timeout = 1'b1;
               state_d     = LOAD;
            end
         end
         DRAIN: begin
            bus.OutValid = 1'b1;
            bus.OutData  = dec_buf[out_cnt];
            bus.OutLast  = (out_cnt == DEC_LAST);
            if (bus.OutReady && (out_cnt == DEC_LAST)) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_cnt      <= 9'd0;
         rd_cnt      <= 9'd0;
         cap_cnt     <= 8'd0;
         tmo_cnt     <= 11'd0;
         out_cnt     <= 8'd0;
         frame_count <= 8'd0;
         frame_err_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         unique case (state_q)
            LOAD: begin
               if (bus.InValid) begin
                  if (wr_cnt == CODED_LAST) begin
                     wr_cnt      <= 9'd0;
                     rd_cnt      <= 9'd0;
                     frame_err_q <= ~bus.InLast;
                  end else if (bus.InLast) begin
                     // Short frame: drop what was collected and start over.
                     wr_cnt      <= 9'd0;
                     frame_err_q <= 1'b1;
                  end else begin
                     wr_cnt <= wr_cnt + 9'd1;
                  end
               end
            end
            FEED: begin
               if (rd_cnt == CODED_LAST) begin
                  rd_cnt  <= 9'd0;
                  cap_cnt <= 8'd0;
                  tmo_cnt <= 11'd0;
               end else begin
                  rd_cnt <= rd_cnt + 9'd1;
               end
            end
            CAPTURE: begin
               tmo_cnt <= tmo_cnt + 11'd1;
               if (cap_done) begin
                  cap_cnt <= 8'd0;
                  out_cnt <= 8'd0;
               end else if (tmo_cnt == TMO_LAST) begin
                  cap_cnt <= 8'd0;
                  tmo_cnt <= 11'd0;
               end else if (bus.DecOutValid) begin
                  cap_cnt <= cap_cnt + 8'd1;
               end
            end
            DRAIN: begin
               if (bus.OutReady) begin
                  if (out_cnt == DEC_LAST) begin
                     out_cnt     <= 8'd0;
                     frame_count <= frame_count + 8'd1;
                  end else begin
                     out_cnt <= out_cnt + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if ((state_q == LOAD) && bus.InValid) begin
         coded_buf[wr_cnt] <= bus.InData;
      end
      if ((state_q == CAPTURE) && bus.DecOutValid) begin
         dec_buf[cap_cnt] <= bus.DecOutput;
      end
   end

   assign bus.Busy       = (state_q != LOAD);
   assign bus.FrameError = frame_err_q;
   assign bus.FrameCount = frame_count;

endmodule

// File: tb/tb_viterbi_frame_controller.sv
// Purpose: directed self-checking bench for viterbi_frame_controller.
// Latency: inputs change on the falling edge, outputs are sampled on the falling edge (or 1 ns after an input change).
// Backpressure: OutReady is dropped mid-drain and on the last bit to check that the output holds.
module tb_viterbi_frame_controller;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 Clock = ~Clock;

   viterbi_frame_controller_if bus ();

   viterbi_frame_controller #(
      .MAX_LENGTH   (192),
      .CODED_LENGTH (384),
      .TIMEOUT      (1024)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (bus)
   );

   // Stimulus only: sends n alternating bits (1,0,1,...) with InLast on last_idx.
   task automatic send_bits(input int n, input int last_idx);
      for (int i = 0; i < n; i++) begin
         bus.InValid = 1'b1;
         bus.InData  = ((i % 2) == 0);
         bus.InLast  = (i == last_idx);
         @(negedge Clock);
      end
      bus.InValid = 1'b0;
      bus.InLast  = 1'b0;
      bus.InData  = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(negedge Clock);
      checks++;
      if (bus.InReady !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.InReady); end
      checks++;
      if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.Busy); end
      checks++;
      if ({bus.DecStart, bus.DecInput, bus.OutData, bus.OutValid, bus.OutLast, bus.FrameError, bus.Timeout} !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs got %b want 0000000",
                  {bus.DecStart, bus.DecInput, bus.OutData, bus.OutValid, bus.OutLast, bus.FrameError, bus.Timeout});
      end
      checks++;
      if (bus.FrameCount !== 8'd0) begin errors++; $display("FAIL reset_frame_count got %0d want 0", bus.FrameCount); end
      Reset = 1'b0;
      @(negedge Clock);
      checks++;
      if ({bus.InReady, bus.Busy} !== 2'b10) begin errors++; $display("FAIL post_reset_idle got %b want 10", {bus.InReady, bus.Busy}); end
   endtask

   // Full alternating frame, replay into the decoder, then CAPTURE entry.
   task automatic test_feed();
      logic exp;
      send_bits(384, 383);
      checks++;
      if ({bus.Busy, bus.InReady, bus.FrameError} !== 3'b100) begin
         errors++; $display("FAIL feed_entry got busy/inready/frameerror %b want 100", {bus.Busy, bus.InReady, bus.FrameError});
      end
      for (int i = 0; i < 384; i++) begin
         exp = ((i % 2) == 0);
         checks++;
         if (bus.DecStart !== (i == 0)) begin errors++; $display("FAIL feed_dec_start rd=%0d got %0b want %0b", i, bus.DecStart, (i == 0)); end
         checks++;
         if (bus.DecInput !== exp) begin errors++; $display("FAIL feed_dec_input rd=%0d got %0b want %0b", i, bus.DecInput, exp); end
         @(negedge Clock);
      end
      checks++;
      if ({bus.Busy, bus.InReady, bus.OutValid, bus.DecStart, bus.DecInput} !== 5'b10000) begin
         errors++;
         $display("FAIL capture_entry got %b want 10000", {bus.Busy, bus.InReady, bus.OutValid, bus.DecStart, bus.DecInput});
      end
   endtask

   // Decoder returns 0xA5 repeating (MSB first) with random gaps; drain checks every bit.
   task automatic test_decode_drain();
      logic [7:0] pat;
      logic       exp;
      int         gap;
      pat = 8'hA5;
      for (int j = 0; j < 192; j++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            bus.DecOutValid = 1'b0;
            bus.DecOutput   = $urandom_range(0, 1) == 1;
            @(negedge Clock);
         end
         bus.DecOutValid = 1'b1;
         bus.DecOutput   = pat[3'(7 - (j % 8))];
         @(negedge Clock);
      end
      bus.DecOutValid = 1'b0;
      bus.DecOutput   = 1'b0;
      bus.OutReady    = 1'b1;
      for (int k = 0; k < 192; k++) begin
         exp = pat[3'(7 - (k % 8))];
         checks++;
         if (bus.OutValid !== 1'b1) begin errors++; $display("FAIL drain_valid k=%0d got %0b want 1", k, bus.OutValid); end
         checks++;
         if (bus.OutData !== exp) begin errors++; $display("FAIL drain_data k=%0d got %0b want %0b", k, bus.OutData, exp); end
         checks++;
         if (bus.OutLast !== (k == 191)) begin errors++; $display("FAIL drain_last k=%0d got %0b want %0b", k, bus.OutLast, (k == 191)); end
         @(negedge Clock);
      end
      checks++;
      if ({bus.InReady, bus.Busy, bus.OutValid} !== 3'b100) begin
         errors++; $display("FAIL drain_exit got %b want 100", {bus.InReady, bus.Busy, bus.OutValid});
      end
      checks++;
      if (bus.FrameCount !== 8'd1) begin errors++; $display("FAIL frame_count_1 got %0d want 1", bus.FrameCount); end
   endtask

   // InLast on bit 100, then a clean full frame.
   task automatic test_frame_error();
      logic exp;
      send_bits(101, 100);
      checks++;
      if (bus.FrameError !== 1'b1) begin errors++; $display("FAIL short_frame_error got %0b want 1", bus.FrameError); end
      checks++;
      if ({bus.InReady, bus.Busy} !== 2'b10) begin errors++; $display("FAIL short_frame_state got %b want 10", {bus.InReady, bus.Busy}); end
      @(negedge Clock);
      checks++;
      if (bus.FrameError !== 1'b0) begin errors++; $display("FAIL short_frame_pulse_width got %0b want 0", bus.FrameError); end
      send_bits(384, 383);
      checks++;
      if (bus.FrameError !== 1'b0) begin errors++; $display("FAIL good_frame_error got %0b want 0", bus.FrameError); end
      for (int i = 0; i < 384; i++) begin
         exp = ((i % 2) == 0);
         checks++;
         if (bus.DecStart !== (i == 0)) begin errors++; $display("FAIL refeed_dec_start rd=%0d got %0b want %0b", i, bus.DecStart, (i == 0)); end
         checks++;
         if (bus.DecInput !== exp) begin errors++; $display("FAIL refeed_dec_input rd=%0d got %0b want %0b", i, bus.DecInput, exp); end
         @(negedge Clock);
      end
   endtask

   // Decoder returns 0x5A repeating; OutReady drops for 10 cycles at bit 100 and at the last bit.
   task automatic test_backpressure();
      logic [7:0] pat;
      logic       exp;
      pat = 8'h5A;
      for (int j = 0; j < 192; j++) begin
         bus.DecOutValid = 1'b1;
         bus.DecOutput   = pat[3'(7 - (j % 8))];
         @(negedge Clock);
      end
      bus.DecOutValid = 1'b0;
      bus.DecOutput   = 1'b0;
      bus.OutReady    = 1'b1;
      for (int k = 0; k < 192; k++) begin
         exp = pat[3'(7 - (k % 8))];
         if (k == 100 || k == 191) begin
            bus.OutReady = 1'b0;
            for (int s = 0; s < 10; s++) begin
               checks++;
               if ({bus.OutValid, bus.OutData, bus.OutLast} !== {1'b1, exp, (k == 191)}) begin
                  errors++;
                  $display("FAIL stall_hold k=%0d s=%0d got %b want %b", k, s,
                           {bus.OutValid, bus.OutData, bus.OutLast}, {1'b1, exp, (k == 191)});
               end
               @(negedge Clock);
            end
            bus.OutReady = 1'b1;
         end
         checks++;
         if (bus.OutData !== exp) begin errors++; $display("FAIL bp_data k=%0d got %0b want %0b", k, bus.OutData, exp); end
         checks++;
         if (bus.OutLast !== (k == 191)) begin errors++; $display("FAIL bp_last k=%0d got %0b want %0b", k, bus.OutLast, (k == 191)); end
         @(negedge Clock);
      end
      checks++;
      if ({bus.InReady, bus.Busy} !== 2'b10) begin errors++; $display("FAIL bp_exit got %b want 10", {bus.InReady, bus.Busy}); end
      checks++;
      if (bus.FrameCount !== 8'd2) begin errors++; $display("FAIL frame_count_2 got %0d want 2", bus.FrameCount); end
   endtask

   // No decoder output: Timeout on the 1024th CAPTURE cycle, then back in LOAD.
   task automatic test_timeout();
      send_bits(384, 383);
      repeat (384) @(negedge Clock);
      for (int c = 1; c <= 1024; c++) begin
         checks++;
         if (bus.Timeout !== (c == 1024)) begin errors++; $display("FAIL timeout_pulse c=%0d got %0b want %0b", c, bus.Timeout, (c == 1024)); end
         @(negedge Clock);
      end
      checks++;
      if ({bus.InReady, bus.Busy, bus.Timeout, bus.OutValid} !== 4'b1000) begin
         errors++; $display("FAIL timeout_exit got %b want 1000", {bus.InReady, bus.Busy, bus.Timeout, bus.OutValid});
      end
      checks++;
      if (bus.FrameCount !== 8'd2) begin errors++; $display("FAIL timeout_frame_count got %0d want 2", bus.FrameCount); end
   endtask

   // Last decoded bit lands on the timeout cycle: completion wins.
   task automatic test_timeout_race();
      send_bits(384, 383);
      repeat (384) @(negedge Clock);
      for (int c = 1; c <= 1024; c++) begin
         bus.DecOutValid = (c <= 191) || (c == 1024);
         bus.DecOutput   = ((c % 2) == 1);
         #1;
         checks++;
         if (bus.Timeout !== 1'b0) begin errors++; $display("FAIL race_timeout c=%0d got %0b want 0", c, bus.Timeout); end
         @(negedge Clock);
      end
      bus.DecOutValid = 1'b0;
      bus.DecOutput   = 1'b0;
      bus.OutReady    = 1'b1;
      checks++;
      if ({bus.OutValid, bus.Busy, bus.InReady} !== 3'b110) begin
         errors++; $display("FAIL race_drain_entry got %b want 110", {bus.OutValid, bus.Busy, bus.InReady});
      end
      for (int k = 0; k < 192; k++) begin
         checks++;
         if (bus.OutData !== ((k % 2 == 0) && (k != 191))) begin
            errors++; $display("FAIL race_data k=%0d got %0b want %0b", k, bus.OutData, ((k % 2 == 0) && (k != 191)));
         end
         @(negedge Clock);
      end
      checks++;
      if (bus.FrameCount !== 8'd3) begin errors++; $display("FAIL frame_count_3 got %0d want 3", bus.FrameCount); end
   endtask

   // Reset at rd_cnt=50 aborts the frame; the next frame starts cleanly.
   task automatic test_reset_mid_feed();
      send_bits(384, 383);
      repeat (50) @(negedge Clock);
      checks++;
      if ({bus.Busy, bus.DecStart} !== 2'b10) begin errors++; $display("FAIL mid_feed_state got %b want 10", {bus.Busy, bus.DecStart}); end
      Reset = 1'b1;
      #1;
      checks++;
      if ({bus.InReady, bus.Busy} !== 2'b10) begin errors++; $display("FAIL mid_reset_idle got %b want 10", {bus.InReady, bus.Busy}); end
      checks++;
      if ({bus.DecStart, bus.DecInput, bus.OutData, bus.OutValid, bus.OutLast, bus.FrameError, bus.Timeout} !== 7'b0) begin
         errors++;
         $display("FAIL mid_reset_outputs got %b want 0000000",
                  {bus.DecStart, bus.DecInput, bus.OutData, bus.OutValid, bus.OutLast, bus.FrameError, bus.Timeout});
      end
      checks++;
      if (bus.FrameCount !== 8'd0) begin errors++; $display("FAIL mid_reset_frame_count got %0d want 0", bus.FrameCount); end
      @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      checks++;
      if ({bus.InReady, bus.Busy, bus.DecStart, bus.OutValid} !== 4'b1000) begin
         errors++; $display("FAIL post_abort_idle got %b want 1000", {bus.InReady, bus.Busy, bus.DecStart, bus.OutValid});
      end
      send_bits(384, 383);
      checks++;
      if ({bus.DecStart, bus.DecInput} !== 2'b11) begin errors++; $display("FAIL restart_first got %b want 11", {bus.DecStart, bus.DecInput}); end
      @(negedge Clock);
      checks++;
      if ({bus.DecStart, bus.DecInput} !== 2'b00) begin errors++; $display("FAIL restart_second got %b want 00", {bus.DecStart, bus.DecInput}); end
   endtask

   initial begin
      bus.InData      = 1'b0;
      bus.InValid     = 1'b0;
      bus.InLast      = 1'b0;
      bus.DecOutput   = 1'b0;
      bus.DecOutValid = 1'b0;
      bus.OutReady    = 1'b1;
      test_reset();
      test_feed();
      test_decode_drain();
      test_frame_error();
      test_backpressure();
      test_timeout();
      test_timeout_race();
      test_reset_mid_feed();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
